implication_trail: RTL and testbench



---
 rtl/implication_trail.sv | 214 +++++++++++++++++++++
 tb/tb_implication_trail.sv | 348 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/implication_trail.sv
// implication_trail: LIFO trail of variable assignments for the solver.
// Implications and decisions are pushed in order. On backtrack the trail
// unwinds newest-first, emitting one unassign beat per entry over a
// valid/ready port, and stops after popping the most recent decision.
// A backtrack with no open decision level parks the block in UNSAT.
//
// Optional build macro: IMPLY_TRAIL_HWM_EN adds the hwm output, which is the
// high-water mark of the stack pointer since reset.
//
// Handshake: a pop beat transfers on a rising edge where pop_valid and
// pop_ready are both high. While pop_valid is high and pop_ready is low, the
// pop_* fields hold steady. pop_valid never drops until its beat is taken,
// except on reset.
module implication_trail #(
  parameter int VAR_IDX_W = 9,
  parameter int DEPTH     = 512,
  parameter int LVL_W     = 10
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 push_en,
  input  logic [VAR_IDX_W-1:0] push_var_idx,
  input  logic                 push_val,
  input  logic                 push_is_dec,
  input  logic                 backtrack_req,
  output logic                 pop_valid,
  input  logic                 pop_ready,
  output logic [VAR_IDX_W-1:0] pop_var_idx,
  output logic                 pop_val,
  output logic                 pop_is_dec,
  output logic                 busy,
  output logic                 bt_done,
  output logic                 unsat,
  output logic                 overflow,
  output logic [LVL_W-1:0]     level,
  output logic                 empty,
  output logic                 full
`ifdef IMPLY_TRAIL_HWM_EN
  ,
  output logic [LVL_W-1:0]     hwm
`endif
);

  localparam int              ADDR_W  = $clog2(DEPTH);
  localparam logic [LVL_W-1:0] ONE    = LVL_W'(1);
  localparam logic [LVL_W-1:0] DEPTH_L = LVL_W'(DEPTH);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    UNWIND = 2'd1,
    DONE   = 2'd2,
    UNSAT  = 2'd3
  } state_t;

  typedef struct packed {
    logic [VAR_IDX_W-1:0] var_idx;
    logic                 val;
    logic                 is_dec;
  } entry_t;

  // Trail storage; intentionally not cleared by reset.
  entry_t mem [DEPTH];

  state_t           state_q, state_d;
  logic [LVL_W-1:0] sp_q, sp_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic             overflow_q, overflow_d;

  logic             wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [ADDR_W-1:0] top_addr;
  entry_t           wr_entry;
  entry_t           top_entry;
  logic             push_window;
  logic             is_full;
  logic             is_empty;

  assign is_full   = (sp_q == DEPTH_L);
  assign is_empty  = (sp_q == '0);
  assign wr_addr   = ADDR_W'(sp_q);
  assign top_addr  = ADDR_W'(sp_q - ONE);
  assign top_entry = mem[top_addr];
  assign wr_entry  = '{var_idx: push_var_idx, val: push_val, is_dec: push_is_dec};

  // Pushes are only honoured while the trail is not unwinding or dead.
  assign push_window = (state_q == IDLE) || (state_q == DONE);

  // Next-state, stack pointer, level and handshake outputs.
  always_comb begin
    state_d    = state_q;
    sp_d       = sp_q;
    level_d    = level_q;
    overflow_d = overflow_q;
    wr_en      = 1'b0;
    pop_valid  = 1'b0;
    bt_done    = 1'b0;

    if (push_window && push_en) begin
      if (!is_full) begin
        wr_en = 1'b1;
        sp_d  = sp_q + ONE;
        if (push_is_dec) begin
          level_d = level_q + ONE;
        end
      end else begin
        overflow_d = 1'b1;
      end
    end

    case (state_q)
      IDLE: begin
        // A same-cycle decision push opens a level, so the post-push level
        // decides between unwinding and UNSAT.
        if (backtrack_req) begin
          if (level_d == '0) begin
            state_d = UNSAT;
          end else begin
            state_d = UNWIND;
          end
        end
      end
      UNWIND: begin
        if (is_empty) begin
          // Unreachable while level <= sp holds; recover rather than stall.
          state_d = IDLE;
        end else begin
          pop_valid = 1'b1;
          if (pop_ready) begin
            sp_d = sp_q - ONE;
            if (top_entry.is_dec) begin
              level_d = level_q - ONE;
              state_d = DONE;
            end
          end
        end
      end
      DONE: begin
        bt_done = 1'b1;
        state_d = IDLE;
      end
      UNSAT: begin
        state_d = UNSAT;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Control registers with asynchronous active-low reset.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      sp_q       <= '0;
      level_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      sp_q       <= sp_d;
      level_q    <= level_d;
      overflow_q <= overflow_d;
    end
  end

  // Trail write port.
  always_ff @(posedge clock) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_entry;
    end
  end

  // Pop fields are forced to zero whenever no beat is offered.
  always_comb begin
    pop_var_idx = '0;
    pop_val     = 1'b0;
    pop_is_dec  = 1'b0;
    if (pop_valid) begin
      pop_var_idx = top_entry.var_idx;
      pop_val     = top_entry.val;
      pop_is_dec  = top_entry.is_dec;
    end
  end

  assign busy     = (state_q != IDLE);
  assign unsat    = (state_q == UNSAT);
  assign overflow = overflow_q;
  assign level    = level_q;
  assign empty    = is_empty;
  assign full     = is_full;

`ifdef IMPLY_TRAIL_HWM_EN
  logic [LVL_W-1:0] hwm_q, hwm_d;

  // High-water mark follows sp upward on the same edge as the push.
  always_comb begin
    hwm_d = hwm_q;
    if (sp_d > hwm_q) begin
      hwm_d = sp_d;
    end
  end

  // High-water mark register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      hwm_q <= '0;
    end else begin
      hwm_q <= hwm_d;
    end
  end

  assign hwm = hwm_q;
`endif

endmodule

// File: tb/tb_implication_trail.sv
// tb_implication_trail: directed-vector bench for implication_trail.
// Inputs change 1 time unit after the falling edge; outputs are sampled there
// too, well away from the rising (active) edge.
module tb_implication_trail;

  localparam int VAR_IDX_W = 9;
  localparam int DEPTH     = 512;
  localparam int LVL_W     = 10;

  logic                 clock;
  logic                 reset;
  logic                 push_en;
  logic [VAR_IDX_W-1:0] push_var_idx;
  logic                 push_val;
  logic                 push_is_dec;
  logic                 backtrack_req;
  logic                 pop_valid;
  logic                 pop_ready;
  logic [VAR_IDX_W-1:0] pop_var_idx;
  logic                 pop_val;
  logic                 pop_is_dec;
  logic                 busy;
  logic                 bt_done;
  logic                 unsat;
  logic                 overflow;
  logic [LVL_W-1:0]     level;
  logic                 empty;
  logic                 full;
`ifdef IMPLY_TRAIL_HWM_EN
  logic [LVL_W-1:0]     hwm;
`endif

  int n_pass;
  int n_total;

  implication_trail #(
    .VAR_IDX_W(VAR_IDX_W),
    .DEPTH    (DEPTH),
    .LVL_W    (LVL_W)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .push_en      (push_en),
    .push_var_idx (push_var_idx),
    .push_val     (push_val),
    .push_is_dec  (push_is_dec),
    .backtrack_req(backtrack_req),
    .pop_valid    (pop_valid),
    .pop_ready    (pop_ready),
    .pop_var_idx  (pop_var_idx),
    .pop_val      (pop_val),
    .pop_is_dec   (pop_is_dec),
    .busy         (busy),
    .bt_done      (bt_done),
    .unsat        (unsat),
    .overflow     (overflow),
    .level        (level),
    .empty        (empty),
    .full         (full)
`ifdef IMPLY_TRAIL_HWM_EN
    ,
    .hwm          (hwm)
`endif
  );

  // Clock and reset block.
  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic apply_reset();
    reset         = 1'b0;
    push_en       = 1'b0;
    push_var_idx  = '0;
    push_val      = 1'b0;
    push_is_dec   = 1'b0;
    backtrack_req = 1'b0;
    pop_ready     = 1'b0;
    repeat (2) @(negedge clock);
    #1;
    reset = 1'b1;
  endtask

  // Driver: one push, occupying one rising edge.
  task automatic do_push(input int v, input logic val, input logic dec);
    push_en      = 1'b1;
    push_var_idx = VAR_IDX_W'(v);
    push_val     = val;
    push_is_dec  = dec;
    @(negedge clock);
    #1;
    push_en     = 1'b0;
    push_is_dec = 1'b0;
  endtask

  // Driver: one-cycle backtrack pulse; returns in the first UNWIND cycle.
  task automatic do_backtrack();
    backtrack_req = 1'b1;
    @(negedge clock);
    #1;
    backtrack_req = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    n_total++;
    if ({pop_valid, busy, bt_done, unsat, overflow, empty, full} !== 7'b0000010 || level !== '0) begin
      $display("FAIL reset_outputs: got v=%b b=%b d=%b u=%b o=%b e=%b f=%b lvl=%0d want 0000010 lvl=0",
               pop_valid, busy, bt_done, unsat, overflow, empty, full, level);
    end else n_pass++;
`ifdef IMPLY_TRAIL_HWM_EN
    n_total++;
    if (hwm !== '0) $display("FAIL reset_hwm: got %0d want 0", hwm);
    else n_pass++;
`endif
  endtask

  task automatic test_basic_unwind();
    int ev [3] = '{3, 2, 1};
    logic evl [3] = '{1'b1, 1'b1, 1'b0};
    logic ed [3] = '{1'b0, 1'b0, 1'b1};
    apply_reset();
    do_push(1, 1'b0, 1'b1);
    do_push(2, 1'b1, 1'b0);
    do_push(3, 1'b1, 1'b0);
    n_total++;
    if (level !== LVL_W'(1) || empty !== 1'b0) $display("FAIL t1_pre: got lvl=%0d e=%b want lvl=1 e=0", level, empty);
    else n_pass++;
    pop_ready = 1'b1;
    do_backtrack();
    for (int i = 0; i < 3; i++) begin
      n_total++;
      if (pop_valid !== 1'b1 || pop_var_idx !== VAR_IDX_W'(ev[i]) || pop_val !== evl[i] || pop_is_dec !== ed[i]) begin
        $display("FAIL t1_beat%0d: got v=%b (%0d,%b,%b) want v=1 (%0d,%b,%b)",
                 i, pop_valid, pop_var_idx, pop_val, pop_is_dec, ev[i], evl[i], ed[i]);
      end else n_pass++;
      @(negedge clock);
      #1;
    end
    n_total++;
    if (bt_done !== 1'b1 || pop_valid !== 1'b0 || level !== '0 || empty !== 1'b1) begin
      $display("FAIL t1_done: got d=%b v=%b lvl=%0d e=%b want d=1 v=0 lvl=0 e=1", bt_done, pop_valid, level, empty);
    end else n_pass++;
    @(negedge clock);
    #1;
    n_total++;
    if (bt_done !== 1'b0 || busy !== 1'b0) $display("FAIL t1_idle: got d=%b b=%b want d=0 b=0", bt_done, busy);
    else n_pass++;
  endtask

  task automatic test_unsat();
    apply_reset();
    do_backtrack();
    n_total++;
    if (unsat !== 1'b1 || busy !== 1'b1 || pop_valid !== 1'b0) begin
      $display("FAIL t2_unsat: got u=%b b=%b v=%b want u=1 b=1 v=0", unsat, busy, pop_valid);
    end else n_pass++;
    do_push(5, 1'b1, 1'b1);
    do_push(6, 1'b0, 1'b0);
    n_total++;
    if (unsat !== 1'b1 || empty !== 1'b1 || level !== '0) begin
      $display("FAIL t2_push_ignored: got u=%b e=%b lvl=%0d want u=1 e=1 lvl=0", unsat, empty, level);
    end else n_pass++;
    reset = 1'b0;
    #1;
    n_total++;
    if (unsat !== 1'b0 || busy !== 1'b0) $display("FAIL t2_reset_clear: got u=%b b=%b want u=0 b=0", unsat, busy);
    else n_pass++;
    apply_reset();
  endtask

  task automatic test_two_levels();
    int ev [4] = '{7, 6, 5, 4};
    logic evl [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic ed [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    apply_reset();
    do_push(4, 1'b1, 1'b1);
    do_push(5, 1'b0, 1'b0);
    do_push(6, 1'b1, 1'b1);
    do_push(7, 1'b0, 1'b0);
    n_total++;
    if (level !== LVL_W'(2)) $display("FAIL t3_level2: got %0d want 2", level);
    else n_pass++;
    pop_ready = 1'b1;
    for (int r = 0; r < 2; r++) begin
      do_backtrack();
      for (int i = 0; i < 2; i++) begin
        n_total++;
        if (pop_valid !== 1'b1 || pop_var_idx !== VAR_IDX_W'(ev[2*r+i]) || pop_val !== evl[2*r+i] ||
            pop_is_dec !== ed[2*r+i]) begin
          $display("FAIL t3_round%0d_beat%0d: got v=%b (%0d,%b,%b) want v=1 (%0d,%b,%b)", r, i, pop_valid,
                   pop_var_idx, pop_val, pop_is_dec, ev[2*r+i], evl[2*r+i], ed[2*r+i]);
        end else n_pass++;
        @(negedge clock);
        #1;
      end
      n_total++;
      if (bt_done !== 1'b1 || pop_valid !== 1'b0 || level !== LVL_W'(1 - r) || empty !== (r == 1)) begin
        $display("FAIL t3_round%0d_done: got d=%b v=%b lvl=%0d e=%b want d=1 v=0 lvl=%0d e=%b",
                 r, bt_done, pop_valid, level, empty, 1 - r, (r == 1));
      end else n_pass++;
      @(negedge clock);
      #1;
    end
  endtask

  task automatic test_stall();
    logic rdy [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    int ev [3] = '{12, 11, 10};
    int idx = 0;
    apply_reset();
    do_push(10, 1'b0, 1'b1);
    do_push(11, 1'b1, 1'b0);
    do_push(12, 1'b0, 1'b0);
    do_backtrack();
    for (int c = 0; c < 6; c++) begin
      pop_ready = rdy[c];
      #1;
      n_total++;
      if (idx < 3) begin
        if (pop_valid !== 1'b1 || pop_var_idx !== VAR_IDX_W'(ev[idx]) || pop_is_dec !== (idx == 2)) begin
          $display("FAIL t4_cycle%0d: got v=%b var=%0d dec=%b want v=1 var=%0d dec=%b",
                   c, pop_valid, pop_var_idx, pop_is_dec, ev[idx], (idx == 2));
        end else n_pass++;
      end else begin
        if (bt_done !== 1'b1 || pop_valid !== 1'b0) begin
          $display("FAIL t4_cycle%0d_done: got d=%b v=%b want d=1 v=0", c, bt_done, pop_valid);
        end else n_pass++;
      end
      if (rdy[c] && idx < 3) idx++;
      @(negedge clock);
      #1;
    end
    n_total++;
    if (empty !== 1'b1 || level !== '0 || busy !== 1'b0) begin
      $display("FAIL t4_end: got e=%b lvl=%0d b=%b want e=1 lvl=0 b=0", empty, level, busy);
    end else n_pass++;
  endtask

  task automatic test_full_overflow();
    apply_reset();
    do_push(100, 1'b1, 1'b1);
    for (int i = 1; i < DEPTH; i++) begin
      do_push(i % 256, 1'(i), 1'b0);
    end
    n_total++;
    if (full !== 1'b1 || overflow !== 1'b0) $display("FAIL t5_full: got f=%b o=%b want f=1 o=0", full, overflow);
    else n_pass++;
    do_push(9, 1'b1, 1'b0);
    n_total++;
    if (full !== 1'b1 || overflow !== 1'b1 || level !== LVL_W'(1)) begin
      $display("FAIL t5_overflow: got f=%b o=%b lvl=%0d want f=1 o=1 lvl=1", full, overflow, level);
    end else n_pass++;
`ifdef IMPLY_TRAIL_HWM_EN
    n_total++;
    if (hwm !== LVL_W'(DEPTH)) $display("FAIL t5_hwm: got %0d want %0d", hwm, DEPTH);
    else n_pass++;
`endif
  endtask

  task automatic test_back_to_back();
    apply_reset();
    do_push(8, 1'b0, 1'b1);
    pop_ready     = 1'b1;
    push_en       = 1'b1;
    push_var_idx  = VAR_IDX_W'(9);
    push_val      = 1'b1;
    push_is_dec   = 1'b0;
    backtrack_req = 1'b1;
    @(negedge clock);
    #1;
    push_en       = 1'b0;
    backtrack_req = 1'b0;
    n_total++;
    if (pop_valid !== 1'b1 || pop_var_idx !== VAR_IDX_W'(9) || pop_val !== 1'b1 || pop_is_dec !== 1'b0) begin
      $display("FAIL t5_simul_beat0: got v=%b (%0d,%b,%b) want v=1 (9,1,0)", pop_valid, pop_var_idx, pop_val, pop_is_dec);
    end else n_pass++;
    @(negedge clock);
    #1;
    n_total++;
    if (pop_valid !== 1'b1 || pop_var_idx !== VAR_IDX_W'(8) || pop_val !== 1'b0 || pop_is_dec !== 1'b1) begin
      $display("FAIL t5_simul_beat1: got v=%b (%0d,%b,%b) want v=1 (8,0,1)", pop_valid, pop_var_idx, pop_val, pop_is_dec);
    end else n_pass++;
    @(negedge clock);
    #1;
    n_total++;
    if (bt_done !== 1'b1 || empty !== 1'b1) $display("FAIL t5_simul_done: got d=%b e=%b want d=1 e=1", bt_done, empty);
    else n_pass++;
  endtask

  task automatic test_reset_mid_unwind();
    apply_reset();
    do_push(20, 1'b1, 1'b1);
    do_push(21, 1'b0, 1'b0);
    do_push(22, 1'b1, 1'b0);
    pop_ready = 1'b1;
    do_backtrack();
    @(negedge clock);
    #1;
    n_total++;
    if (pop_valid !== 1'b1 || pop_var_idx !== VAR_IDX_W'(21)) begin
      $display("FAIL t6_beat2: got v=%b var=%0d want v=1 var=21", pop_valid, pop_var_idx);
    end else n_pass++;
    reset = 1'b0;
    #1;
    n_total++;
    if (pop_valid !== 1'b0 || busy !== 1'b0 || empty !== 1'b1 || level !== '0) begin
      $display("FAIL t6_async: got v=%b b=%b e=%b lvl=%0d want v=0 b=0 e=1 lvl=0", pop_valid, busy, empty, level);
    end else n_pass++;
    @(negedge clock);
    #1;
    reset = 1'b1;
`ifdef IMPLY_TRAIL_HWM_EN
    n_total++;
    if (hwm !== '0) $display("FAIL t6_hwm_reset: got %0d want 0", hwm);
    else n_pass++;
`endif
    do_push(30, 1'b0, 1'b1);
    do_push(31, 1'b1, 1'b0);
    do_push(32, 1'b0, 1'b0);
`ifdef IMPLY_TRAIL_HWM_EN
    n_total++;
    if (hwm !== LVL_W'(3)) $display("FAIL t6_hwm3: got %0d want 3", hwm);
    else n_pass++;
`endif
    do_backtrack();
    n_total++;
    if (pop_valid !== 1'b1 || pop_var_idx !== VAR_IDX_W'(32)) begin
      $display("FAIL t6_after_reset: got v=%b var=%0d want v=1 var=32", pop_valid, pop_var_idx);
    end else n_pass++;
  endtask

  // Test sequence and final report.
  initial begin
    n_pass  = 0;
    n_total = 0;
    test_reset();
    test_basic_unwind();
    test_unsat();
    test_two_levels();
    test_stall();
    test_full_overflow();
    test_back_to_back();
    test_reset_mid_unwind();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
